// File: rtl/writeback_regfile.sv
// Writeback stage: selects load/ALU result, commits it to a 32x32 register file,
// serves two decode read ports and a forwarding tap. Optional macro WB_FWD_EN adds
// a same-cycle write-to-read bypass on both read ports.
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     regWrite_Wb_In,
  input  logic                     memToRegWrite_Wb_In,
  input  logic [XLEN-1:0]          readD_Wb_In,
  input  logic [XLEN-1:0]          aluOut_Wb_In,
  input  logic [$clog2(NREG)-1:0]  rd_Wb_In,
  input  logic [$clog2(NREG)-1:0]  rs1_Id_In,
  input  logic [$clog2(NREG)-1:0]  rs2_Id_In,
  output logic [XLEN-1:0]          rs1Data_Id_Out,
  output logic [XLEN-1:0]          rs2Data_Id_Out,
  output logic [XLEN-1:0]          wbData_Out,
  output logic                     wbValid_Out,
  output logic [CNT_W-1:0]         retireCnt_Out
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]  regs [NREG];
  logic [CNT_W-1:0] retire_cnt;
  logic             commit;

  assign wbData_Out    = memToRegWrite_Wb_In ? readD_Wb_In : aluOut_Wb_In;
  assign commit        = regWrite_Wb_In && (rd_Wb_In != '0);
  assign wbValid_Out   = commit;
  assign retireCnt_Out = retire_cnt;

  // x0 is never a commit target, so its storage stays at its reset value of 0
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      retire_cnt <= '0;
    end else if (commit) begin
      regs[rd_Wb_In] <= wbData_Out;
      retire_cnt     <= retire_cnt + 1'b1;
    end
  end

  always_comb begin
    rs1Data_Id_Out = regs[rs1_Id_In];
    rs2Data_Id_Out = regs[rs2_Id_In];
`ifdef WB_FWD_EN
    // each port resolves the bypass independently; commit already excludes x0
    if (commit && (rs1_Id_In == rd_Wb_In)) rs1Data_Id_Out = wbData_Out;
    if (commit && (rs2_Id_In == rd_Wb_In)) rs2Data_Id_Out = wbData_Out;
`endif
    if (rs1_Id_In == AW'(0)) rs1Data_Id_Out = '0;
    if (rs2_Id_In == AW'(0)) rs2Data_Id_Out = '0;
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: expected values are queued when stimulus is
// driven and popped when the DUT output is sampled. Counter width is 4 to reach wrap.
module tb_writeback_regfile;

  logic        clk;
  logic        rstN;
  logic        regWrite_Wb_In;
  logic        memToRegWrite_Wb_In;
  logic [31:0] readD_Wb_In;
  logic [31:0] aluOut_Wb_In;
  logic [4:0]  rd_Wb_In;
  logic [4:0]  rs1_Id_In;
  logic [4:0]  rs2_Id_In;
  logic [31:0] rs1Data_Id_Out;
  logic [31:0] rs2Data_Id_Out;
  logic [31:0] wbData_Out;
  logic        wbValid_Out;
  logic [3:0]  retireCnt_Out;
  logic [31:0] cnt_ext;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];
  logic [3:0]  mcnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  writeback_regfile #(.XLEN(32), .NREG(32), .CNT_W(4)) dut (
    .clk                 (clk),
    .rstN                (rstN),
    .regWrite_Wb_In      (regWrite_Wb_In),
    .memToRegWrite_Wb_In (memToRegWrite_Wb_In),
    .readD_Wb_In         (readD_Wb_In),
    .aluOut_Wb_In        (aluOut_Wb_In),
    .rd_Wb_In            (rd_Wb_In),
    .rs1_Id_In           (rs1_Id_In),
    .rs2_Id_In           (rs2_Id_In),
    .rs1Data_Id_Out      (rs1Data_Id_Out),
    .rs2Data_Id_Out      (rs2Data_Id_Out),
    .wbData_Out          (wbData_Out),
    .wbValid_Out         (wbValid_Out),
    .retireCnt_Out       (retireCnt_Out)
  );

  assign cnt_ext = {28'd0, retireCnt_Out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h required=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // advance one rising edge and apply the expected commit to the model
  task automatic step();
    @(posedge clk);
    if (rstN && regWrite_Wb_In && rd_Wb_In != 5'd0) begin
      model[rd_Wb_In] = memToRegWrite_Wb_In ? readD_Wb_In : aluOut_Wb_In;
      mcnt = mcnt + 4'd1;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic mem, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [4:0] rd);
    regWrite_Wb_In      = we;
    memToRegWrite_Wb_In = mem;
    readD_Wb_In         = rdata;
    aluOut_Wb_In        = alu;
    rd_Wb_In            = rd;
  endtask

  task automatic read_both(input string tag, input logic [4:0] a, input logic [4:0] b);
    rs1_Id_In = a;
    rs2_Id_In = b;
    push({tag, "_rs1"}, model[a]);
    push({tag, "_rs2"}, model[b]);
    #1;
    pop_check(rs1Data_Id_Out);
    pop_check(rs2Data_Id_Out);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    mcnt = 4'd0;
    rstN = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    rs1_Id_In = 5'd0;
    rs2_Id_In = 5'd0;
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    #1;

    // reset state
    for (int i = 0; i < 32; i++) read_both("reset", 5'(i), 5'(31 - i));
    push("reset_cnt", 32'd0);
    pop_check(cnt_ext);

    // ALU commit
    drive(1'b1, 1'b0, 32'h0BAD_F00D, 32'hDEAD_BEEF, 5'd5);
    push("alu_wbdata", 32'hDEAD_BEEF);
    push("alu_wbvalid", 32'd1);
    #1;
    pop_check(wbData_Out);
    pop_check({31'd0, wbValid_Out});
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    push("alu_wbvalid_idle", 32'd0);
    #1;
    pop_check({31'd0, wbValid_Out});
    read_both("alu_read", 5'd5, 5'd5);
    push("alu_cnt", {28'd0, mcnt});
    pop_check(cnt_ext);

    // load commit
    drive(1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd31);
    push("load_wbdata", 32'h1234_5678);
    #1;
    pop_check(wbData_Out);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    read_both("load_read", 5'd5, 5'd31);
    push("load_cnt", 32'd2);
    pop_check(cnt_ext);

    // x0 write is ignored
    drive(1'b1, 1'b0, 32'd0, 32'hA5A5_A5A5, 5'd0);
    push("x0_wbvalid", 32'd0);
    #1;
    pop_check({31'd0, wbValid_Out});
    read_both("x0_pre", 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    read_both("x0_post", 5'd0, 5'd31);
    push("x0_cnt", 32'd2);
    pop_check(cnt_ext);

    // bypass case on reg7
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0011, 5'd7);
    step();
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0042, 5'd7);
    rs1_Id_In = 5'd7;
    rs2_Id_In = 5'd7;
`ifdef WB_FWD_EN
    push("byp_rs1", 32'h0000_0042);
    push("byp_rs2", 32'h0000_0042);
`else
    push("byp_rs1", 32'h0000_0011);
    push("byp_rs2", 32'h0000_0011);
`endif
    #1;
    pop_check(rs1Data_Id_Out);
    pop_check(rs2Data_Id_Out);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    read_both("byp_next", 5'd7, 5'd7);
    push("byp_cnt", 32'd4);
    pop_check(cnt_ext);

    // idle writeback with junk data leaves state untouched
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    push("idle_wbdata", 32'hFFFF_FFFF);
    #1;
    pop_check(wbData_Out);
    step();
    read_both("idle_read", 5'd5, 5'd31);
    push("idle_cnt", 32'd4);
    pop_check(cnt_ext);

    // async reset mid-cycle, with a write pending across the next edge
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0333, 5'd3);
    rs1_Id_In = 5'd5;
    rs2_Id_In = 5'd31;
    #2;
    rstN = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    mcnt = 4'd0;
    push("arst_rs1", 32'd0);
    push("arst_rs2", 32'd0);
    push("arst_cnt", 32'd0);
    #1;
    pop_check(rs1Data_Id_Out);
    pop_check(rs2Data_Id_Out);
    pop_check(cnt_ext);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    rstN = 1'b1;
    read_both("arst_discard", 5'd3, 5'd7);
    push("arst_cnt_after", 32'd0);
    pop_check(cnt_ext);

    // counter wrap on a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'd0, 32'(i + 1), 5'd1);
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    push("wrap16_cnt", 32'd0);
    #1;
    pop_check(cnt_ext);
    read_both("wrap16_read", 5'd1, 5'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd17, 5'd1);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    push("wrap17_cnt", 32'd1);
    #1;
    pop_check(cnt_ext);
    read_both("wrap17_read", 5'd1, 5'd1);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (load data or ALU result) and commits it to a 32x32 integer register file.
- Provides two combinational read ports to the decode stage and a forwarding tap to the EX-stage forwarding unit.
- Maintains a retired-writeback counter for the performance/debug path.

Parameters:
- XLEN, 32, data width of registers and writeback values
- NREG, 32, number of architectural registers; rd/rs index width is $clog2(NREG)
- CNT_W, 64, width of the writeback-retire counter

Ports:
- clk  input  1  system clock, rising-edge
- rstN  input  1  asynchronous, active-low reset
- regWrite_Wb_In  input  1  write enable from MEM/WB register
- memToRegWrite_Wb_In  input  1  1 = commit readD, 0 = commit aluOut
- readD_Wb_In  input  XLEN  load data from MEM/WB register
- aluOut_Wb_In  input  XLEN  ALU result from MEM/WB register
- rd_Wb_In  input  5  destination register index
- rs1_Id_In  input  5  decode read port 1 index
- rs2_Id_In  input  5  decode read port 2 index
- rs1Data_Id_Out  output  XLEN  read port 1 data
- rs2Data_Id_Out  output  XLEN  read port 2 data
- wbData_Out  output  XLEN  muxed writeback value (combinational), to the forwarding unit
- wbValid_Out  output  1  regWrite_Wb_In && rd_Wb_In != 0 (combinational)
- retireCnt_Out  output  CNT_W  count of committed register writes

Behaviour:
- Reset (rstN low, asynchronous): all NREG registers clear to 0 and retireCnt_Out clears to 0. Read outputs then return 0. Reset asserted mid-operation discards any write on that edge.
- wbData_Out = memToRegWrite_Wb_In ? readD_Wb_In : aluOut_Wb_In. Pure mux, no latency.
- Commit rule: on a rising clk edge with rstN high and regWrite_Wb_In=1 and rd_Wb_In!=0, reg[rd_Wb_In] <= wbData_Out.
  - Single-cycle write latency; the register holds its value otherwise.
- x0 rule: register 0 is never written and always reads 0, regardless of the writeback inputs.
- Reads: rsNData_Id_Out is combinational from the array.
  - With WB_FWD_EN defined, a same-cycle write to the same nonzero index is bypassed; see Optional Feature.
- retireCnt_Out increments by 1 on every edge where a commit occurs. Writes to x0 do not count.
  - Wraps modulo 2^CNT_W from all-ones to 0 with no sticky flag.
- Both read ports may address the same register, including rd_Wb_In, simultaneously; each port resolves independently.
- regWrite_Wb_In=0: wbData_Out is still driven; no state change; wbValid_Out=0.
- X handling: if regWrite_Wb_In=0, the data/rd inputs are don't-care and must not corrupt state.

Optional Feature:
- Macro: WB_FWD_EN
- Defined: internal write-to-read bypass. If regWrite_Wb_In=1, rd_Wb_In!=0 and rsN_Id_In==rd_Wb_In, then rsNData_Id_Out = wbData_Out in the same cycle. The decode stage sees the value being written with zero bubble.
- Not defined: reads return the pre-edge array contents. The new value is visible from the cycle after the commit edge, so the hazard unit must stall or forward externally.

Test Plan:
- Reset: hold rstN=0, then release. All 32 registers read 0 via both ports and retireCnt_Out=0. Assert rstN=0 asynchronously between edges: outputs go to 0 immediately.
- ALU commit: regWrite=1, memToReg=0, aluOut=0xDEADBEEF, rd=5, one edge. Next cycle rs1=5 reads 0xDEADBEEF and retireCnt_Out=1.
- Load commit: regWrite=1, memToReg=1, readD=0x12345678, aluOut=0xFFFFFFFF, rd=31. Then wbData_Out=0x12345678 before the edge, and rs2=31 reads 0x12345678 after the edge.
- x0 write: regWrite=1, rd=0, aluOut=0xA5A5A5A5. wbValid_Out=0, rs1=0 reads 0, and retireCnt_Out is unchanged.
- Bypass: rd=7=rs1=rs2, aluOut=0x00000042, with reg7 previously 0x11.
  - With WB_FWD_EN: both ports read 0x42 in the write cycle.
  - Without it: both read 0x11, then 0x42 in the next cycle.
- Counter wrap with CNT_W=4: 16 consecutive commits to rd=1 return retireCnt_Out to 0; 17 commits give 1.
